// File: rtl/acc_pkg.sv
// acc_pkg: shared constants for the accumulator CPU sequencer.
//   - ADDR_W / DATA_W defaults, wait-counter width
//   - opcode encodings (instr[DATA_W-1:DATA_W-3])
//   - alu_op encodings driven to the accumulator/ALU
//   - sequencer state encodings
package acc_pkg;

    localparam int ACC_ADDR_W   = 5;
    localparam int ACC_DATA_W   = 8;
    localparam int ACC_MAX_WAIT = 15;
    localparam int WAIT_W       = 8;   // holds MAX_WAIT up to 255

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_OPREAD  = 3'd2;
    localparam logic [2:0] ST_OPWRITE = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    // Only LDA/ADD/SUB ever reach the operand-read state.
    function automatic logic [1:0] alu_for_op(input logic [2:0] op);
        logic [1:0] sel;
        sel = ALU_PASS;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/acc_wait_timer.sv
// acc_wait_timer: counts consecutive memory wait cycles.
// Ports:
//   clock    in   system clock
//   reset    in   async active-low reset, clears the count
//   clear    in   synchronous clear (state change)
//   enable   in   count one more wait cycle
//   expired  out  count has reached MAX_WAIT
module acc_wait_timer
    import acc_pkg::*;
#(
    parameter int MAX_WAIT = ACC_MAX_WAIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/acc_ctrl.sv
// acc_ctrl: instruction-sequencing FSM for the accumulator CPU.
// Optional build macro: ACC_CTRL_STEP_EN adds the `step` input; FETCH then
// only completes in a cycle with mem_ready=1 and step=1.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   async active-low reset (forces all outputs to 0)
//   pc         in   current program counter
//   mem_rdata  in   memory read data (valid with mem_ready)
//   mem_ready  in   memory completes the current access this cycle
//   acc_zero   in   accumulator is zero
//   step       in   single-step qualifier (ACC_CTRL_STEP_EN only)
//   pc_inc     out  pc increments at next edge
//   pc_load    out  pc loads pc_target at next edge
//   pc_target  out  jump target (IR address field)
//   rmem       out  memory read request
//   wmem       out  memory write request
//   mem_addr   out  memory address
//   acc_we     out  accumulator write enable
//   alu_op     out  00 pass, 01 add, 10 sub
//   halted     out  in HALT
//   fault      out  in FAULT
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction at pc, latch into IR on ready
// DECODE   | one cycle: drive pc control, pick next state
// OPREAD   | read operand at IR addr, acc_we on ready
// OPWRITE  | write accumulator to IR addr, done on ready
// HALT     | HLT executed, absorbing until reset
// FAULT    | memory wait limit exceeded, absorbing until reset
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int ADDR_W   = ACC_ADDR_W,
    parameter int DATA_W   = ACC_DATA_W,
    parameter int MAX_WAIT = ACC_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              acc_zero,
`ifdef ACC_CTRL_STEP_EN
    input  logic              step,
`endif
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              rmem,
    output logic              wmem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              acc_we,
    output logic [1:0]        alu_op,
    output logic              halted,
    output logic              fault
);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] ir;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              step_ok;
    logic              mem_state;
    logic              fetch_done;
    logic              expired;

`ifdef ACC_CTRL_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign opcode     = ir[DATA_W-1:DATA_W-3];
    assign ir_addr    = ir[ADDR_W-1:0];
    assign mem_state  = (state == ST_FETCH) || (state == ST_OPREAD) ||
                        (state == ST_OPWRITE);
    assign fetch_done = (state == ST_FETCH) && mem_ready && step_ok;

    // A responding memory never counts as a wait cycle, even when step
    // holds off the fetch.
    acc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_next != state),
        .enable  (mem_state && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (fetch_done)                   state_next = ST_DECODE;
                else if (!mem_ready && expired)   state_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: state_next = ST_OPREAD;
                    OP_STA:                 state_next = ST_OPWRITE;
                    OP_HLT:                 state_next = ST_HALT;
                    default:                state_next = ST_FETCH;
                endcase
            end
            ST_OPREAD, ST_OPWRITE: begin
                if (mem_ready)                    state_next = ST_FETCH;
                else if (expired)                 state_next = ST_FAULT;
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (fetch_done) begin
                ir <= mem_rdata;
            end
        end
    end

    // Outputs are gated by the reset level so an access in flight is
    // dropped the moment reset falls, before any clock edge.
    always_comb begin
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        rmem      = 1'b0;
        wmem      = 1'b0;
        mem_addr  = '0;
        acc_we    = 1'b0;
        alu_op    = ALU_PASS;
        halted    = 1'b0;
        fault     = 1'b0;
        if (reset) begin
            pc_target = ir_addr;
            case (state)
                ST_FETCH: begin
                    rmem     = 1'b1;
                    mem_addr = pc;
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_JMP:  pc_load = 1'b1;
                        OP_JZ: begin
                            pc_load = acc_zero;
                            pc_inc  = !acc_zero;
                        end
                        OP_HLT:  pc_inc = 1'b0;
                        default: pc_inc = 1'b1;
                    endcase
                end
                ST_OPREAD: begin
                    rmem     = 1'b1;
                    mem_addr = ir_addr;
                    alu_op   = alu_for_op(opcode);
                    acc_we   = mem_ready;
                end
                ST_OPWRITE: begin
                    wmem     = 1'b1;
                    mem_addr = ir_addr;
                end
                ST_HALT:  halted = 1'b1;
                ST_FAULT: fault  = 1'b1;
                default:  fault  = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: self-checking bench for acc_ctrl. The bench models the pc
// block and a unified memory; each test pushes per-cycle expected outputs
// to a scoreboard queue together with the inputs for that cycle, then pops
// and compares them as the cycles run.
module tb_acc_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] pc;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b0;
    logic       acc_zero = 1'b0;
    logic       step = 1'b1;
    logic       pc_inc, pc_load, rmem, wmem, acc_we, halted, fault;
    logic [4:0] pc_target, mem_addr;
    logic [1:0] alu_op;

    logic [7:0] mem [32];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_load;
        logic       rmem;
        logic       wmem;
        logic       acc_we;
        logic       halted;
        logic       fault;
        logic [1:0] alu;
        logic [4:0] addr;
        logic [4:0] tgt;
    } exp_t;

    typedef struct packed {
        logic ready;
        logic az;
        exp_t e;
    } cyc_t;

    cyc_t sb[$];

    acc_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .acc_zero  (acc_zero),
`ifdef ACC_CTRL_STEP_EN
        .step      (step),
`endif
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .rmem      (rmem),
        .wmem      (wmem),
        .mem_addr  (mem_addr),
        .acc_we    (acc_we),
        .alu_op    (alu_op),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    // pc block model
    always @(posedge clock or negedge reset) begin
        if (!reset)       pc <= 5'd0;
        else if (pc_load) pc <= pc_target;
        else if (pc_inc)  pc <= pc + 5'd1;
    end

    assign mem_rdata = mem[mem_addr];

    function automatic exp_t mk(input logic inc, input logic load,
                                input logic rd, input logic wr,
                                input logic we, input logic h, input logic f,
                                input logic [1:0] alu, input logic [4:0] a,
                                input logic [4:0] t);
        exp_t e;
        e.pc_inc  = inc;
        e.pc_load = load;
        e.rmem    = rd;
        e.wmem    = wr;
        e.acc_we  = we;
        e.halted  = h;
        e.fault   = f;
        e.alu     = we ? alu : 2'b00;
        e.addr    = (rd || wr) ? a : 5'd0;
        e.tgt     = load ? t : 5'd0;
        return e;
    endfunction

    function automatic exp_t x_fetch(input logic [4:0] a);
        return mk(0, 0, 1, 0, 0, 0, 0, 2'b00, a, 5'd0);
    endfunction
    function automatic exp_t x_inc();
        return mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0);
    endfunction
    function automatic exp_t x_load(input logic [4:0] t);
        return mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 5'd0, t);
    endfunction
    function automatic exp_t x_read(input logic [4:0] a, input logic we,
                                    input logic [1:0] alu);
        return mk(0, 0, 1, 0, we, 0, 0, alu, a, 5'd0);
    endfunction
    function automatic exp_t x_write(input logic [4:0] a);
        return mk(0, 0, 0, 1, 0, 0, 0, 2'b00, a, 5'd0);
    endfunction
    function automatic exp_t x_idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0);
    endfunction
    function automatic exp_t x_halt();
        return mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 5'd0, 5'd0);
    endfunction
    function automatic exp_t x_fault();
        return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 5'd0, 5'd0);
    endfunction

    // Observed outputs, with fields that carry no meaning for the expected
    // cycle zeroed (address without a strobe, target without a load, ...).
    function automatic exp_t sample(input exp_t want);
        exp_t o;
        o.pc_inc  = pc_inc;
        o.pc_load = pc_load;
        o.rmem    = rmem;
        o.wmem    = wmem;
        o.acc_we  = acc_we;
        o.halted  = halted;
        o.fault   = fault;
        o.alu     = want.acc_we ? alu_op : 2'b00;
        o.addr    = (want.rmem || want.wmem) ? mem_addr : 5'd0;
        o.tgt     = want.pc_load ? pc_target : 5'd0;
        return o;
    endfunction

    function automatic logic [18:0] raw_outputs();
        return {pc_inc, pc_load, rmem, wmem, acc_we, halted, fault,
                alu_op, mem_addr, pc_target};
    endfunction

    task automatic push(input logic r, input logic az, input exp_t e);
        cyc_t c;
        c.ready = r;
        c.az    = az;
        c.e     = e;
        sb.push_back(c);
    endtask

    task automatic drive(input logic r, input logic az);
        @(negedge clock);
        mem_ready = r;
        acc_zero  = az;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    // Reset asserted across one edge, released just after a rising edge so
    // the first cycle after release is a full FETCH cycle.
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b0;
        acc_zero  = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        total++;
        if (raw_outputs() !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", raw_outputs());
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_nop();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'hC0;
        mem[1] = 8'hC0;
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(0, 0, x_inc());
        push(0, 0, x_fetch(5'd1));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL nop cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_alu_reads();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'h05;   // LDA 5
        mem[1] = 8'h45;   // ADD 5
        mem[2] = 8'h65;   // SUB 5
        mem[5] = 8'h2A;
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(0, 0, x_inc());
        push(1, 0, x_read(5'd5, 1, 2'b00));
        push(1, 0, x_fetch(5'd1));
        push(0, 0, x_inc());
        push(0, 0, x_read(5'd5, 0, 2'b00));
        push(1, 0, x_read(5'd5, 1, 2'b01));
        push(1, 0, x_fetch(5'd2));
        push(0, 0, x_inc());
        push(1, 0, x_read(5'd5, 1, 2'b10));
        push(0, 0, x_fetch(5'd3));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL alu_reads cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_jumps();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0]  = 8'hAF;  // JZ 15, taken
        mem[15] = 8'hAF;  // JZ 15, not taken
        mem[16] = 8'h83;  // JMP 3
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(0, 1, x_load(5'd15));
        push(1, 0, x_fetch(5'd15));
        push(0, 0, x_inc());
        push(1, 0, x_fetch(5'd16));
        push(0, 1, x_load(5'd3));
        push(0, 0, x_fetch(5'd3));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL jumps cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_store_wait();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'h27;   // STA 7
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(0, 0, x_inc());
        for (int i = 0; i < 3; i++) push(0, 0, x_write(5'd7));
        push(1, 0, x_write(5'd7));
        push(0, 0, x_fetch(5'd1));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL store_wait cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    // 15 wait cycles, then ready in the cycle the limit is reached: completes.
    task automatic test_wait_limit();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'hC0;
        do_reset();
        for (int i = 0; i < 15; i++) push(0, 0, x_fetch(5'd0));
        push(1, 0, x_fetch(5'd0));
        push(0, 0, x_inc());
        push(0, 0, x_fetch(5'd1));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL wait_limit cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_fault();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        do_reset();
        for (int i = 0; i < 16; i++) push(0, 0, x_fetch(5'd0));
        push(0, 0, x_fault());
        push(1, 0, x_fault());
        push(0, 1, x_fault());
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL fault cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
        do_reset();
        push(0, 0, x_fetch(5'd0));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL fault_clear cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_halt();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'hE0;
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(1, 0, x_idle());
        push(1, 0, x_halt());
        push(1, 1, x_halt());
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL halt cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_read();
        cyc_t c; exp_t o; int n = 0;
        clear_mem();
        mem[0] = 8'h05;
        mem[5] = 8'h2A;
        do_reset();
        push(1, 0, x_fetch(5'd0));
        push(0, 0, x_inc());
        push(0, 0, x_read(5'd5, 0, 2'b00));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL mid_read cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
        // memory answers just as reset falls: nothing may reach the outputs
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        total++;
        if (raw_outputs() !== 19'd0) begin
            bad++; $display("FAIL mid_read_reset got=%h want=0", raw_outputs());
        end
        @(posedge clock);
        #1;
        total++;
        if (raw_outputs() !== 19'd0) begin
            bad++; $display("FAIL mid_read_hold got=%h want=0", raw_outputs());
        end
        #1;
        reset     = 1'b1;
        mem_ready = 1'b0;
        push(0, 0, x_fetch(5'd0));
        while (sb.size() != 0) begin
            c = sb.pop_front(); drive(c.ready, c.az); o = sample(c.e); total++;
            if (o !== c.e) begin
                bad++; $display("FAIL mid_read_after cyc=%0d got=%h want=%h", n, o, c.e);
            end
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mem();
        test_reset();
        test_nop();
        test_alu_reads();
        test_jumps();
        test_store_wait();
        test_wait_limit();
        test_fault();
        test_halt();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
- Instruction-sequencing FSM for the 5-bit-address accumulator CPU.
- Drives the pc block's load/increment controls and the memory read/write strobes, latches the instruction word, and issues accumulator write and ALU-op controls.
- Sits between pc/pc_reg, the unified instruction/data memory and the accumulator/ALU.

Parameters:
- ADDR_W, 5, address/PC width.
- DATA_W, 8, memory word and instruction width; opcode = instr[DATA_W-1:DATA_W-3], operand address = instr[ADDR_W-1:0].
- MAX_WAIT, 15, maximum cycles a memory access waits for mem_ready before faulting (range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current program counter from pc block.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes current access this cycle.
- acc_zero  in  1  accumulator equals zero.
- pc_inc  out  1  pc increments at next edge.
- pc_load  out  1  pc loads pc_target at next edge.
- pc_target  out  ADDR_W  jump target.
- rmem  out  1  memory read request.
- wmem  out  1  memory write request (data = accumulator).
- mem_addr  out  ADDR_W  memory address.
- acc_we  out  1  accumulator write enable.
- alu_op  out  2  00 pass mem_rdata, 01 add, 10 sub.
- halted  out  1  in HALT state.
- fault  out  1  in FAULT state.

Behaviour:
- States: FETCH, DECODE, OPREAD, OPWRITE, HALT, FAULT. Outputs are combinational from the state and IR registers (Moore-style).
- Reset (reset=0, asynchronous): state=FETCH, IR=0, wait counter=0. While reset is low, all outputs are forced to 0. The first fetch starts on the first edge after release.
- FETCH: rmem=1, mem_addr=pc. On mem_ready: IR<=mem_rdata, go to DECODE. Otherwise stay and increment the wait counter.
- DECODE (exactly 1 cycle), by opcode:
  - LDA 000, ADD 010, SUB 011: pc_inc=1, go to OPREAD.
  - STA 001: pc_inc=1, go to OPWRITE.
  - JMP 100: pc_load=1, pc_target=IR addr, go to FETCH.
  - JZ 101: if acc_zero, pc_load=1 with pc_target=IR addr; else pc_inc=1. Go to FETCH.
  - NOP 110: pc_inc=1, go to FETCH.
  - HLT 111: no PC change, go to HALT.
- pc_inc and pc_load are never both 1.
- OPREAD: rmem=1, mem_addr=IR addr, alu_op from opcode (LDA→00, ADD→01, SUB→10). acc_we=1 only in the cycle mem_ready=1; then go to FETCH.
- OPWRITE: wmem=1, mem_addr=IR addr. On mem_ready, go to FETCH.
- Latency with zero wait states:
  - NOP/JMP/JZ: 2 cycles.
  - LDA/ADD/SUB/STA: 3 cycles.
  - Each wait cycle adds 1.
- Wait counter: cleared on every state transition. If a memory state has seen MAX_WAIT consecutive cycles without mem_ready, go to FAULT on the next edge. mem_ready in that same cycle wins and completes normally.
- HALT and FAULT: absorbing; all strobes 0; halted=1 or fault=1 respectively. Exit only via reset.
- mem_ready outside FETCH/OPREAD/OPWRITE is ignored.
- Address arithmetic is the pc block's responsibility; PC wrap 31→0 is transparent to this block.
- Reset asserted mid-access: the access is abandoned immediately; no acc_we or wmem is issued.

Optional Feature:
- Macro ACC_CTRL_STEP_EN adds input port `step` (1 bit).
- With the macro defined: the FETCH→DECODE transition additionally requires step=1. The first cycle that has mem_ready=1 and step=1 latches IR. The wait counter does not advance while mem_ready=1 and step=0.
- Without the macro: no step port; behaviour is as above.

Decomposition:
- Package acc_pkg: opcode constants (OP_LDA..OP_HLT), alu_op encodings, state enum/localparams, and the ADDR_W/DATA_W defaults.
- One sub-module, acc_wait_timer: a counter with clear/enable and an expired output compared against MAX_WAIT.
- The FSM stays in acc_ctrl.

Test Plan:
1. Release reset with memory at 0 holding 0xC0 (NOP), zero wait → rmem=1 addr 0; one cycle later pc_inc=1; FETCH resumes with pc=1.
2. LDA 5 (0x05), mem[5]=0x2A → alu_op=00, and acc_we=1 exactly 1 cycle at mem_addr=5, 2 cycles after the fetch completes.
3. JZ 15 (0xAF): with acc_zero=1 → pc_load=1, pc_target=15; with acc_zero=0 → pc_inc=1 only.
4. STA 7 (0x27) with mem_ready delayed 3 cycles → wmem=1 held 4 cycles at addr 7, then FETCH.
5. mem_ready held low in FETCH → fault=1 after MAX_WAIT=15 cycles, strobes 0; only reset low clears it.
6. HLT (0xE0) → halted=1 and no further rmem. Reset pulsed low mid-OPREAD → outputs 0 immediately and no acc_we.
